uart_receive: RTL and testbench

//  UART receive path with 16x oversampling, the RX end of the serial link (8N1 default).

---
 rtl/uart_receive.sv | 217 +++++++++++++++++++++
 tb/tb_uart_receive.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receive.sv
// ----------------------------------------------------------------------------
// uart_receive
//
// Receive half of a UART link using 16x oversampling (8N1 by default).
// The rx pin is synchronised with two flops. Each frame is then handled by a
// small FSM:
//   - the start bit is confirmed at mid-bit;
//   - data bits are sampled at mid-bit and shifted in LSB first;
//   - the stop bit is sampled at the end of the stop period.
// Each completed frame goes into a one-entry output buffer with a valid/read
// handshake. The buffer also records framing and overrun status.
//
// Parameters
//   DBIT     data bits per frame (5..8)
//   SB_TICK  oversample ticks spent in the stop state
//            (16 = 1, 24 = 1.5, 32 = 2 stop bits)
//
// Ports
//   clk           system clock, single domain
//   reset         synchronous, active-high reset
//   rx            serial input pin; asynchronous, idle high
//   s_tick        one-clk baud pulse, 16 per bit period; shared with the TX side
//   rd_en         pops the buffered byte (ignored while rx_valid = 0)
//   dout          buffered byte, right-aligned, upper 8-DBIT bits zero
//   rx_valid      buffer holds an unread byte
//   rx_done_tick  one-clk pulse when a frame completes, good or bad
//   frame_err     stop bit of the buffered byte was sampled low
//   overrun_err   buffered byte replaced a byte that had not been read
// ----------------------------------------------------------------------------

module uart_receive #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       s_tick,
    input  logic       rd_en,
    output logic [7:0] dout,
    output logic       rx_valid,
    output logic       rx_done_tick,
    output logic       frame_err,
    output logic       overrun_err
);

    // The tick counter must hold 15 (data bits) and also SB_TICK-1 (stop bit).
    localparam int unsigned SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;

    localparam logic [SW-1:0] SMid      = SW'(7);
    localparam logic [SW-1:0] SBitLast  = SW'(15);
    localparam logic [SW-1:0] SStopLast = SW'(SB_TICK - 1);
    localparam logic [2:0]    NLast     = 3'(DBIT - 1);

    // Bits are shifted in at the MSB, so a short frame ends up left-aligned.
    localparam int unsigned Shift = 8 - DBIT;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    // ------------------------------------------------------------------
    // Input synchroniser. It resets to 1 (the line idle level), so the FSM
    // does not see a false start bit straight after reset.
    // ------------------------------------------------------------------
    logic sync1_q;
    logic rx_s_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx;
            rx_s_q  <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM with its datapath registers
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [2:0]    n_q, n_d;
    logic [7:0]    b_q, b_d;
    logic          frame_done;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
        end
    end

    // Next-state logic. Cycles without a tick hold everything, except that
    // idle leaves as soon as the line goes low.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        unique case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    state_d = StStart;
                    s_d     = '0;
                end
            end
            StStart: begin
                if (s_tick) begin
                    if (s_q == SMid) begin
                        // Middle of the start bit: a line that is high again was
                        // only a glitch.
                        if (!rx_s_q) begin
                            state_d = StData;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            StData: begin
                if (s_tick) begin
                    if (s_q == SBitLast) begin
                        s_d = '0;
                        b_d = {rx_s_q, b_q[7:1]};
                        if (n_q == NLast) begin
                            state_d = StStop;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            StStop: begin
                if (s_tick) begin
                    if (s_q == SStopLast) begin
                        state_d = StIdle;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic. A frame completes on the same cycle as the stop -> idle move.
    always_comb begin
        frame_done   = (state_q == StStop) && s_tick && (s_q == SStopLast);
        rx_done_tick = frame_done;
    end

    // ------------------------------------------------------------------
    // One-entry output buffer. A completed frame always loads, even when it
    // has a framing error, because the receiver has no way to hold off the
    // sender.
    // ------------------------------------------------------------------
    logic [7:0] dout_q, dout_d;
    logic       valid_q, valid_d;
    logic       ferr_q, ferr_d;
    logic       ovr_q, ovr_d;

    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
        if (frame_done) begin
            dout_d  = b_q >> Shift;
            ferr_d  = ~rx_s_q;
            // A read on the same cycle as a load drains the old byte, so that
            // case is not an overrun.
            ovr_d   = valid_q & ~rd_en;
            valid_d = 1'b1;
        end else if (rd_en && valid_q) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign dout        = dout_q;
    assign rx_valid    = valid_q;
    assign frame_err   = ferr_q;
    assign overrun_err = ovr_q;

endmodule

// File: tb/tb_uart_receive.sv
// ----------------------------------------------------------------------------
// tb_uart_receive
//
// Bench with two receivers:
//   - u_dut8 : default 8N1 configuration, s_tick high on every clock.
//   - u_dut7 : DBIT=7, SB_TICK=32, s_tick on every 4th clock.
// A reference model tracks the expected contents of the output buffer. It
// works at frame level: each frame has a data value, a stop-bit value and a
// note of whether a read happened on the completion cycle.
// ----------------------------------------------------------------------------

module tb_uart_receive;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       rx1, tick1, rd1;
    logic [7:0] dout1;
    logic       valid1, done1, ferr1, ovr1;
    logic       rx2, tick2, rd2;
    logic [7:0] dout2;
    logic       valid2, done2, ferr2, ovr2;

    uart_receive #(.DBIT(8), .SB_TICK(16)) u_dut8 (
        .clk(clk), .reset(reset), .rx(rx1), .s_tick(tick1), .rd_en(rd1),
        .dout(dout1), .rx_valid(valid1), .rx_done_tick(done1),
        .frame_err(ferr1), .overrun_err(ovr1)
    );

    uart_receive #(.DBIT(7), .SB_TICK(32)) u_dut7 (
        .clk(clk), .reset(reset), .rx(rx2), .s_tick(tick2), .rd_en(rd2),
        .dout(dout2), .rx_valid(valid2), .rx_done_tick(done2),
        .frame_err(ferr2), .overrun_err(ovr2)
    );

    int checks = 0;
    int errors = 0;
    int ndone1 = 0;
    int ndone2 = 0;

    // Count completion pulses seen on each receiver.
    always @(posedge clk) begin
        if (done1) ndone1 <= ndone1 + 1;
        if (done2) ndone2 <= ndone2 + 1;
    end

    // Second receiver gets one tick every 4 clocks.
    initial begin
        int cnt;
        cnt   = 0;
        tick2 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cnt   = (cnt + 1) % 4;
            tick2 = (cnt == 0);
        end
    end

    // Reference model of receiver 1's buffer.
    logic [7:0] m_dout;
    logic       m_valid, m_ferr, m_ovr;
    int         m_done;

    task automatic model_reset();
        m_dout  = 8'h00;
        m_valid = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic model_frame(input logic [7:0] data, input bit stop, input bit rd_at_done);
        m_ovr   = m_valid && !rd_at_done;
        m_dout  = data;
        m_ferr  = !stop;
        m_valid = 1'b1;
        m_done  = m_done + 1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        @(negedge clk);
        check({tag, ".dout"},  32'(dout1),  32'(m_dout));
        check({tag, ".valid"}, 32'(valid1), 32'(m_valid));
        check({tag, ".ferr"},  32'(ferr1),  32'(m_ferr));
        check({tag, ".ovr"},   32'(ovr1),   32'(m_ovr));
        check({tag, ".done"},  32'(ndone1), 32'(m_done));
    endtask

    // Waits for n ticks of the selected receiver, then returns 1 time unit
    // after the last tick edge.
    task automatic wait_ticks(input bit which, input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(posedge clk);
            if (which ? tick2 : tick1) k++;
        end
        #1;
    endtask

    task automatic drive_rx(input bit which, input logic val);
        if (which) rx2 = val;
        else rx1 = val;
    endtask

    task automatic send_frame(input bit which, input logic [7:0] data, input int nbits,
                              input bit stop, input int stop_ticks);
        drive_rx(which, 1'b0);
        wait_ticks(which, 16);
        for (int i = 0; i < nbits; i++) begin
            drive_rx(which, data[i]);
            wait_ticks(which, 16);
        end
        drive_rx(which, stop);
        wait_ticks(which, stop_ticks);
        drive_rx(which, 1'b1);
    endtask

    task automatic do_read();
        @(negedge clk);
        rd1 = 1'b1;
        @(posedge clk);
        #1;
        rd1 = 1'b0;
        m_valid = 1'b0;
    endtask

    // Sends a frame and raises rd_en during its completion cycle.
    task automatic frame_rd_on_done(input logic [7:0] data, input bit stop);
        fork
            send_frame(1'b0, data, 8, stop, 16);
            begin
                bit seen;
                seen = 1'b0;
                for (int c = 0; c < 400; c++) begin
                    @(negedge clk);
                    if (done1) begin
                        seen = 1'b1;
                        break;
                    end
                end
                check("done_seen", 32'(seen), 32'd1);
                rd1 = 1'b1;
                @(posedge clk);
                #1;
                rd1 = 1'b0;
            end
        join
        model_frame(data, stop, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        rx1 = 1'b1; rx2 = 1'b1;
        tick1 = 1'b1;
        rd1 = 1'b0; rd2 = 1'b0;
        m_done = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.dout1",  32'(dout1),  32'h0);
        check("rst.valid1", 32'(valid1), 32'h0);
        check("rst.done1",  32'(done1),  32'h0);
        check("rst.errs1",  32'({ferr1, ovr1}), 32'h0);
        check("rst.dut7",   32'({dout2, valid2, done2, ferr2, ovr2}), 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        wait_ticks(0, 16);

        // Test 1: a good frame, then read it back.
        send_frame(0, 8'hA5, 8, 1'b1, 16);
        model_frame(8'hA5, 1'b1, 1'b0);
        check_model("t1");
        do_read();
        check_model("t1.read");

        // Test 2: a 5-tick low glitch must be rejected; a real frame follows.
        rx1 = 1'b0;
        wait_ticks(0, 5);
        rx1 = 1'b1;
        wait_ticks(0, 32);
        check_model("t2.glitch");
        send_frame(0, 8'h3C, 8, 1'b1, 16);
        model_frame(8'h3C, 1'b1, 1'b0);
        check_model("t2");
        do_read();

        // Test 3: stop bit low gives a framing error, but the byte still loads.
        send_frame(0, 8'h3C, 8, 1'b0, 16);
        model_frame(8'h3C, 1'b0, 1'b0);
        wait_ticks(0, 48);
        check_model("t3");
        do_read();

        // Test 4: overrun, then a read on the completion cycle.
        send_frame(0, 8'h11, 8, 1'b1, 16);
        model_frame(8'h11, 1'b1, 1'b0);
        send_frame(0, 8'h22, 8, 1'b1, 16);
        model_frame(8'h22, 1'b1, 1'b0);
        check_model("t4.ovr");
        do_read();
        send_frame(0, 8'h11, 8, 1'b1, 16);
        model_frame(8'h11, 1'b1, 1'b0);
        frame_rd_on_done(8'h22, 1'b1);
        check_model("t4.rd_done");
        do_read();

        // Test 5: reset in the middle of data bit 4 of 0xFF, with a byte buffered.
        send_frame(0, 8'h77, 8, 1'b1, 16);
        model_frame(8'h77, 1'b1, 1'b0);
        rx1 = 1'b0;
        wait_ticks(0, 16);
        for (int i = 0; i < 4; i++) begin
            rx1 = 1'b1;
            wait_ticks(0, 16);
        end
        wait_ticks(0, 8);
        reset = 1'b1;
        @(posedge clk);
        model_reset();
        check_model("t5.rst");
        check("t5.done_low", 32'(done1), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_ticks(0, 48);
        check_model("t5.after");
        send_frame(0, 8'h5A, 8, 1'b1, 16);
        model_frame(8'h5A, 1'b1, 1'b0);
        check_model("t5.next");
        do_read();

        // Test 6: 7-bit receiver with two stop bits, ticking every 4th clock.
        @(posedge clk);
        #1;
        send_frame(1, 8'h55, 7, 1'b1, 32);
        wait_ticks(1, 4);
        @(negedge clk);
        check("t6.dout",  32'(dout2),  32'h55);
        check("t6.ferr",  32'(ferr2),  32'h0);
        check("t6.valid", 32'(valid2), 32'h1);
        check("t6.done",  32'(ndone2), 32'd1);
        @(posedge clk);
        #1;

        // Random frames with random stop bits and random read timing.
        for (int f = 0; f < 16; f++) begin
            logic [7:0] d;
            bit         stop;
            int         mode;
            d    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            mode = $urandom_range(0, 2);
            if (mode == 1) do_read();
            @(posedge clk);
            #1;
            if (mode == 2) begin
                frame_rd_on_done(d, stop);
            end else begin
                send_frame(0, d, 8, stop, 16);
                model_frame(d, stop, 1'b0);
            end
            wait_ticks(0, stop ? 16 : 48);
            check_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
